// File: rtl/child_resp_collector.sv
// rtl/child_resp_collector.sv - round-robin fan-in of child responses into a FIFO toward the parent (optional stats: RESP_COLLECTOR_STATS_EN)
module child_resp_collector #(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    localparam int IDX_W       = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1,
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CHILDREN-1:0]        child_valid,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
    output logic [NUM_CHILDREN-1:0]        child_ready,
    output logic                           up_valid,
    output logic [DATA_W-1:0]              up_data,
    output logic [IDX_W-1:0]               up_idx,
    input  logic                           up_ready,
    output logic [CNT_W-1:0]               fifo_count,
    output logic [15:0]                    resp_total
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    int                cand;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [IDX_W-1:0]  mem_idx  [FIFO_DEPTH];

    // Round-robin search: first valid child at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_CHILDREN;
            if (!win_found && child_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Full is judged on current occupancy only, so a pop this cycle never frees a slot for a push this cycle.
    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign push = win_found && !full;
    assign pop  = up_valid && up_ready;

    // One-hot ready to the winner and mux of its word into the FIFO.
    always_comb begin
        child_ready = '0;
        push_data   = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (win_idx == IDX_W'(i)) begin
                child_ready[i] = push;
                push_data      = child_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Advance the priority pointer past the child just granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (push) begin
            if (win_idx == IDX_W'(NUM_CHILDREN - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= win_idx + IDX_W'(1);
            end
        end
    end

    // Circular buffer with occupancy count; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_idx[wr_ptr]  <= win_idx;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign up_valid   = (count != '0);
    assign up_data    = mem_data[rd_ptr];
    assign up_idx     = mem_idx[rd_ptr];
    assign fifo_count = count;

`ifdef RESP_COLLECTOR_STATS_EN
    logic [15:0] total_q;

    // Saturating count of accepted child responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= 16'h0000;
        end else if (push && (total_q != 16'hFFFF)) begin
            total_q <= total_q + 16'h0001;
        end
    end

    assign resp_total = total_q;
`else
    assign resp_total = 16'h0000;
`endif

endmodule

// File: tb/tb_child_resp_collector.sv
// tb/tb_child_resp_collector.sv - scoreboard bench for child_resp_collector
module tb_child_resp_collector;

    localparam int N     = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    child_valid;
    logic [N*DW-1:0] child_data;
    logic [N-1:0]    child_ready;
    logic            up_valid;
    logic [DW-1:0]   up_data;
    logic [2:0]      up_idx;
    logic            up_ready;
    logic [2:0]      fifo_count;
    logic [15:0]     resp_total;

    int n_tests;
    int n_fail;

    logic [18:0] sb[$];
    int          m_rr;
    int          m_count;
    logic [15:0] m_total;

    child_resp_collector #(
        .NUM_CHILDREN(N),
        .DATA_W(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .child_valid(child_valid),
        .child_data(child_data),
        .child_ready(child_ready),
        .up_valid(up_valid),
        .up_data(up_data),
        .up_idx(up_idx),
        .up_ready(up_ready),
        .fifo_count(fifo_count),
        .resp_total(resp_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model and scoreboard, evaluated mid-cycle on the falling edge.
    always @(negedge clk) begin
        int          w;
        int          c;
        bit          found;
        bit          m_pop;
        bit          m_push;
        logic [N-1:0] exp_ready;
        logic [18:0] e;
        if (!rst_n) begin
            sb.delete();
            m_rr    = 0;
            m_count = 0;
            m_total = 16'h0000;
        end else begin
            found = 1'b0;
            w     = 0;
            for (int i = 0; i < N; i++) begin
                c = (m_rr + i) % N;
                if (!found && child_valid[c]) begin
                    found = 1'b1;
                    w     = c;
                end
            end
            m_push    = found && (m_count < DEPTH);
            exp_ready = m_push ? (N'(1) << w) : '0;
            m_pop     = (m_count != 0) && up_ready;
            n_tests++;
            if (child_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL sb_child_ready: got %b expected %b", child_ready, exp_ready);
            end
            n_tests++;
            if (up_valid !== (m_count != 0)) begin
                n_fail++;
                $display("FAIL sb_up_valid: got %b expected %b", up_valid, (m_count != 0));
            end
            n_tests++;
`ifdef RESP_COLLECTOR_STATS_EN
            if (resp_total !== m_total) begin
`else
            if (resp_total !== 16'h0000) begin
`endif
                n_fail++;
                $display("FAIL sb_resp_total: got %h expected %h", resp_total, m_total);
            end
            if (m_pop) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got pop with empty scoreboard expected no pop");
                end else begin
                    e = sb.pop_front();
                    if ({up_idx, up_data} !== e) begin
                        n_fail++;
                        $display("FAIL sb_up_word: got idx %0d data %h expected idx %0d data %h",
                                 up_idx, up_data, e[18:16], e[15:0]);
                    end
                end
            end
            if (m_push) begin
                sb.push_back({w[2:0], child_data[w*DW +: DW]});
                m_rr = (w + 1) % N;
                if (m_total != 16'hFFFF) m_total = m_total + 16'h0001;
            end
            m_count = m_count + int'(m_push) - int'(m_pop);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) child_data[i*DW +: DW] = 16'($urandom);
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n       = 1'b0;
        child_valid = '0;
        up_ready    = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        next_cycle();
        rst_n       = 1'b0;
        child_valid = '0;
        up_ready    = 1'b0;
        randomize_data();
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({child_ready, up_valid, up_data, up_idx, fifo_count, resp_total} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ready %b valid %b data %h idx %0d cnt %0d total %h expected all zero",
                     child_ready, up_valid, up_data, up_idx, fifo_count, resp_total);
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        randomize_data();
        child_data[2*DW +: DW] = 16'hA5A5;
        child_valid = 5'b00100;
        up_ready    = 1'b1;
        @(negedge clk);
        n_tests++;
        if (child_ready !== 5'b00100) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected 00100", child_ready);
        end
        next_cycle();
        child_valid = '0;
        @(negedge clk);
        n_tests++;
        if (up_valid !== 1'b1 || up_idx !== 3'd2 || up_data !== 16'hA5A5 || fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_latency: got valid %b idx %0d data %h cnt %0d expected 1 2 a5a5 1",
                     up_valid, up_idx, up_data, fifo_count);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_drain: got cnt %0d expected 0", fifo_count);
        end
    endtask

    task automatic test_rotate();
        do_reset();
        up_ready    = 1'b1;
        child_valid = 5'b11111;
        for (int k = 0; k < 10; k++) begin
            randomize_data();
            @(negedge clk);
            n_tests++;
            if (child_ready !== (N'(1) << (k % N))) begin
                n_fail++;
                $display("FAIL rotate_grant_%0d: got %b expected %b", k, child_ready, N'(1) << (k % N));
            end
            if (k > 0) begin
                n_tests++;
                if (up_valid !== 1'b1 || up_idx !== 3'((k - 1) % N)) begin
                    n_fail++;
                    $display("FAIL rotate_idx_%0d: got valid %b idx %0d expected 1 %0d", k, up_valid, up_idx, (k - 1) % N);
                end
            end
            next_cycle();
        end
        child_valid = '0;
        @(negedge clk);
        n_tests++;
`ifdef RESP_COLLECTOR_STATS_EN
        if (resp_total !== 16'd10) begin
            n_fail++;
            $display("FAIL rotate_total: got %0d expected 10", resp_total);
        end
`else
        if (resp_total !== 16'd0) begin
            n_fail++;
            $display("FAIL rotate_total: got %0d expected 0", resp_total);
        end
`endif
    endtask

    task automatic test_full();
        bit drained;
        do_reset();
        up_ready    = 1'b0;
        child_valid = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            randomize_data();
            @(negedge clk);
            n_tests++;
            if (child_ready !== ((k < DEPTH) ? (N'(1) << k) : N'(0))) begin
                n_fail++;
                $display("FAIL full_grant_%0d: got %b", k, child_ready);
            end
            if (k >= DEPTH) begin
                n_tests++;
                if (fifo_count !== 3'd4) begin
                    n_fail++;
                    $display("FAIL full_count_%0d: got %0d expected 4", k, fifo_count);
                end
            end
            next_cycle();
        end
        child_valid = 5'b00010;
        up_ready    = 1'b1;
        randomize_data();
        @(negedge clk);
        n_tests++;
        if (child_ready !== 5'b00000 || fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_block: got ready %b cnt %0d expected 00000 4", child_ready, fifo_count);
        end
        next_cycle();
        randomize_data();
        @(negedge clk);
        n_tests++;
        if (child_ready !== 5'b00010 || fifo_count !== 3'd3) begin
            n_fail++;
            $display("FAIL full_resume: got ready %b cnt %0d expected 00010 3", child_ready, fifo_count);
        end
        next_cycle();
        child_valid = '0;
        drained = 1'b0;
        for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge clk);
            if (fifo_count == 3'd0) drained = 1'b1;
            else next_cycle();
        end
        n_tests++;
        if (!drained || sb.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain: got cnt %0d left %0d expected 0 0", fifo_count, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        up_ready    = 1'b0;
        child_valid = 5'b11111;
        for (int k = 0; k < 3; k++) begin
            randomize_data();
            @(negedge clk);
            next_cycle();
        end
        child_valid = '0;
        rst_n       = 1'b0;
        @(negedge clk);
        n_tests++;
        if (fifo_count !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_buffered: got %0d expected 3", fifo_count);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (up_valid !== 1'b0 || fifo_count !== 3'd0 || up_data !== 16'h0 || up_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid %b cnt %0d data %h idx %0d expected 0 0 0000 0",
                     up_valid, fifo_count, up_data, up_idx);
        end
        next_cycle();
        child_valid = 5'b11111;
        up_ready    = 1'b1;
        randomize_data();
        @(negedge clk);
        n_tests++;
        if (child_ready !== 5'b00001) begin
            n_fail++;
            $display("FAIL mid_rr_restart: got %b expected 00001", child_ready);
        end
        next_cycle();
        child_valid = '0;
    endtask

    task automatic test_stats();
        do_reset();
        up_ready = 1'b1;
`ifdef RESP_COLLECTOR_STATS_EN
        child_valid = 5'b00001;
        for (int i = 0; i < 65535; i++) next_cycle();
        @(negedge clk);
        n_tests++;
        if (resp_total !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_reach_max: got %h expected ffff", resp_total);
        end
        next_cycle();
        child_valid = '0;
        @(negedge clk);
        n_tests++;
        if (resp_total !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_saturate: got %h expected ffff", resp_total);
        end
`else
        child_valid = 5'b11111;
        for (int i = 0; i < 8; i++) begin
            randomize_data();
            next_cycle();
        end
        child_valid = '0;
        @(negedge clk);
        n_tests++;
        if (resp_total !== 16'h0000) begin
            n_fail++;
            $display("FAIL stats_tied_off: got %h expected 0000", resp_total);
        end
`endif
        next_cycle();
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        child_valid = '0;
        child_data  = '0;
        up_ready    = 1'b0;
        test_reset();
        test_single();
        test_rotate();
        test_full();
        test_reset_mid();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
